etapa_id: RTL and testbench

- Decode stage of the vector processor; sits directly downstream of the fetch stage.
- Consumes the 14-bit instruction word and decodes its fields.
- Reads the vector register file with writeback bypass and detects RAW/WAW hazards via a per-register scoreboard.
- Loads the ID/EX pipeline register and stalls fetch when needed; a HALT opcode parks the stage until reset.

---
 rtl/etapa_id.sv | 213 +++++++++++++++++++++
 tb/tb_etapa_id.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/etapa_id.sv
// Decode stage of the vector processor.
// Splits the 14-bit instruction into fields, reads the 8-entry vector
// register file (with same-cycle writeback bypass), tracks outstanding
// writers in a per-register busy scoreboard, and loads the ID/EX register.
// A HALT parks the stage in HALTED until reset; writebacks still land.
module etapa_id #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [13:0]       if_instr,
    input  logic              if_valid,
    input  logic              ex_stall,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_stall,
    output logic              id_valid,
    output logic [3:0]        id_opcode,
    output logic [REG_AW-1:0] id_rd,
    output logic [DATA_W-1:0] id_rs1_data,
    output logic [DATA_W-1:0] id_rs2_data,
    output logic [3:0]        id_imm,
    output logic              id_we,
    output logic              id_mem_rd,
    output logic              id_mem_wr,
    output logic              id_illegal,
    output logic              halted
);

    localparam int NREG = 1 << REG_AW;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_VLD  = 4'hA;
    localparam logic [3:0] OP_VST  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic {RUN, HALTED} state_t;

    state_t state_reg, state_next;

    logic [DATA_W-1:0] rf [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   wb_mask;
    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   busy_eff;

    // Instruction fields
    logic [3:0]        op;
    logic [REG_AW-1:0] f_rd;
    logic [REG_AW-1:0] f_rs1;
    logic [REG_AW-1:0] f_rs2;
    logic [REG_AW-1:0] src2;

    // Decoded controls
    logic dec_use1;
    logic dec_use2;
    logic dec_we;
    logic dec_mem_rd;
    logic dec_mem_wr;
    logic dec_reserved;
    logic dec_halt;

    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic              hazard;
    logic              issue;

    assign op    = if_instr[13:10];
    assign f_rd  = if_instr[9:7];
    assign f_rs1 = if_instr[6:4];
    assign f_rs2 = if_instr[3:1];
    // VST carries its store data in the rd field
    assign src2  = (op == OP_VST) ? f_rd : f_rs2;

    // Opcode decode into source usage and EX-side control bits
    always_comb begin
        dec_use1     = 1'b0;
        dec_use2     = 1'b0;
        dec_we       = 1'b0;
        dec_mem_rd   = 1'b0;
        dec_mem_wr   = 1'b0;
        dec_reserved = 1'b0;
        dec_halt     = 1'b0;
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                dec_use1 = 1'b1;
                dec_use2 = 1'b1;
                dec_we   = 1'b1;
            end
            4'h8, 4'h9: begin
                dec_use1 = 1'b1;
                dec_we   = 1'b1;
            end
            OP_VLD: begin
                dec_use1   = 1'b1;
                dec_we     = 1'b1;
                dec_mem_rd = 1'b1;
            end
            OP_VST: begin
                dec_use1   = 1'b1;
                dec_use2   = 1'b1;
                dec_mem_wr = 1'b1;
            end
            4'hC, 4'hD, 4'hE: dec_reserved = 1'b1;
            OP_HALT:          dec_halt     = 1'b1;
            default: ;
        endcase
    end

    // Operand read with same-cycle writeback bypass
    always_comb begin
        rs1_val = rf[f_rs1];
        rs2_val = rf[src2];
        if (wb_en && (wb_addr == f_rs1)) rs1_val = wb_data;
        if (wb_en && (wb_addr == src2))  rs2_val = wb_data;
    end

    // Scoreboard view: a register being written back this cycle is no longer busy
    always_comb begin
        wb_mask = '0;
        if (wb_en) wb_mask[wb_addr] = 1'b1;
        busy_eff = busy & ~wb_mask;
    end

    // RAW on used sources, WAW on rd; only meaningful for a live instruction in RUN
    always_comb begin
        hazard = 1'b0;
        if (if_valid && (state_reg == RUN)) begin
            hazard = (dec_use1 && busy_eff[f_rs1]) ||
                     (dec_use2 && busy_eff[src2])  ||
                     (dec_we   && busy_eff[f_rd]);
        end
    end

    assign issue    = !ex_stall && !flush && (state_reg == RUN) && if_valid && !hazard;
    assign halted   = (state_reg == HALTED);
    assign id_stall = ex_stall || hazard || halted;

    // Busy bit to raise for an issuing writer
    always_comb begin
        set_mask = '0;
        if (issue && dec_we) set_mask[f_rd] = 1'b1;
    end

    // Register file and scoreboard, one slice per register; set beats clear
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rf[gi]   <= '0;
                busy[gi] <= 1'b0;
            end else begin
                if (wb_mask[gi]) rf[gi] <= wb_data;
                if (set_mask[gi])     busy[gi] <= 1'b1;
                else if (wb_mask[gi]) busy[gi] <= 1'b0;
            end
        end
    end

    // Run/halt state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= RUN;
        else        state_reg <= state_next;
    end

    // Enter HALTED only when a HALT actually issues
    always_comb begin
        state_next = state_reg;
        if (state_reg == RUN && issue && dec_halt) state_next = HALTED;
    end

    // Reserved opcodes are remembered until reset
    always_ff @(posedge clk) begin
        if (!rst_n)                      id_illegal <= 1'b0;
        else if (issue && dec_reserved)  id_illegal <= 1'b1;
    end

    // ID/EX register: hold on ex_stall, otherwise load an instruction or a bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_valid    <= 1'b0;
            id_opcode   <= '0;
            id_rd       <= '0;
            id_rs1_data <= '0;
            id_rs2_data <= '0;
            id_imm      <= '0;
            id_we       <= 1'b0;
            id_mem_rd   <= 1'b0;
            id_mem_wr   <= 1'b0;
        end else if (!ex_stall) begin
            id_rd       <= f_rd;
            id_rs1_data <= rs1_val;
            id_rs2_data <= rs2_val;
            id_imm      <= if_instr[3:0];
            if (issue && !dec_halt) begin
                id_valid  <= 1'b1;
                id_opcode <= dec_reserved ? OP_NOP : op;
                id_we     <= dec_we;
                id_mem_rd <= dec_mem_rd;
                id_mem_wr <= dec_mem_wr;
            end else begin
                id_valid  <= 1'b0;
                id_opcode <= OP_NOP;
                id_we     <= 1'b0;
                id_mem_rd <= 1'b0;
                id_mem_wr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_etapa_id.sv
// Directed bench for the decode stage: inputs change 1 time unit after the
// rising edge, registered outputs are checked at the same point.
module tb_etapa_id;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] if_instr;
    logic        if_valid;
    logic        ex_stall;
    logic        flush;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic        id_stall;
    logic        id_valid;
    logic [3:0]  id_opcode;
    logic [2:0]  id_rd;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [3:0]  id_imm;
    logic        id_we;
    logic        id_mem_rd;
    logic        id_mem_wr;
    logic        id_illegal;
    logic        halted;

    int checks = 0;
    int passes = 0;

    etapa_id #(.DATA_W(32), .REG_AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_valid(if_valid),
        .ex_stall(ex_stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .id_stall(id_stall), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_rd(id_rd), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_we(id_we),
        .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_illegal(id_illegal),
        .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [13:0] instr, input logic valid);
        if_instr = instr;
        if_valid = valid;
    endtask

    task automatic wb(input logic en, input logic [2:0] a, input logic [31:0] d);
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
    endtask

    initial begin
        rst_n = 1'b0; ex_stall = 1'b0; flush = 1'b0;
        drive(14'h0, 1'b0);
        wb(1'b0, 3'd0, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst_valid", id_valid, 0);
        chk("rst_opcode", id_opcode, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", id_illegal, 0);
        chk("rst_stall", id_stall, 0);
        $display("txn reset");

        // r3 = 0x11223344
        wb(1'b1, 3'd3, 32'h11223344);
        tick();
        wb(1'b0, 3'd0, 32'h0);

        // VXOR r1,r3,r3
        drive(enc(4'h1, 3'd1, 3'd3, 3'd3), 1'b1);
        #1 chk("vxor_nostall", id_stall, 0);
        tick();
        chk("vxor_valid", id_valid, 1);
        chk("vxor_opcode", id_opcode, 4'h1);
        chk("vxor_rd", id_rd, 3'd1);
        chk("vxor_rs1", id_rs1_data, 32'h11223344);
        chk("vxor_rs2", id_rs2_data, 32'h11223344);
        chk("vxor_we", id_we, 1);
        $display("txn VXOR r1,r3,r3");

        // VADD r2,r1,r0 while r1 is busy -> stall until wb r1
        drive(enc(4'h6, 3'd2, 3'd1, 3'd0), 1'b1);
        #1 chk("raw_stall", id_stall, 1);
        tick();
        chk("raw_bubble", id_valid, 0);
        chk("raw_bubble_we", id_we, 0);
        chk("raw_stall_hold", id_stall, 1);
        wb(1'b1, 3'd1, 32'h000000AA);
        #1 chk("raw_release", id_stall, 0);
        tick();
        wb(1'b0, 3'd0, 32'h0);
        chk("vadd_valid", id_valid, 1);
        chk("vadd_opcode", id_opcode, 4'h6);
        chk("vadd_rs1_bypass", id_rs1_data, 32'hAA);
        chk("vadd_rs2", id_rs2_data, 32'h0);
        $display("txn VADD r2,r1,r0 after bypass");

        // VSUB r6,r3,r1 held by ex_stall for 3 cycles
        drive(enc(4'h7, 3'd6, 3'd3, 3'd1), 1'b1);
        ex_stall = 1'b1;
        #1 chk("exs_stall", id_stall, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("exs_hold_valid", id_valid, 1);
            chk("exs_hold_opcode", id_opcode, 4'h6);
        end
        ex_stall = 1'b0;
        #1 chk("exs_release", id_stall, 0);
        tick();
        chk("vsub_opcode", id_opcode, 4'h7);
        chk("vsub_rd", id_rd, 3'd6);
        chk("vsub_rs1", id_rs1_data, 32'h11223344);
        chk("vsub_rs2", id_rs2_data, 32'hAA);
        $display("txn VSUB r6,r3,r1 after ex_stall");

        // flushed VADDI r4 must not mark r4 busy
        drive(enc(4'h9, 3'd4, 3'd3, 3'd2) | 14'h1, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_bubble", id_valid, 0);
        #1 chk("flush_no_busy", id_stall, 0);
        tick();
        chk("vaddi_valid", id_valid, 1);
        chk("vaddi_opcode", id_opcode, 4'h9);
        chk("vaddi_imm", id_imm, 4'h5);
        chk("vaddi_rs1", id_rs1_data, 32'h11223344);
        $display("txn flush then VADDI r4,r3,5");

        // reserved opcode D issues as NOP and sets sticky illegal
        drive(14'h3400, 1'b1);
        tick();
        chk("ill_flag", id_illegal, 1);
        chk("ill_valid", id_valid, 1);
        chk("ill_opcode", id_opcode, 4'h0);
        chk("ill_we", id_we, 0);
        drive(14'h0, 1'b0);
        tick();
        chk("ill_sticky", id_illegal, 1);
        chk("idle_bubble", id_valid, 0);
        $display("txn reserved opcode 0xD");

        // VST r3 -> [r1]: data from rd routed to rs2_data
        drive(enc(4'hB, 3'd3, 3'd1, 3'd0), 1'b1);
        tick();
        chk("vst_memwr", id_mem_wr, 1);
        chk("vst_we", id_we, 0);
        chk("vst_addr", id_rs1_data, 32'hAA);
        chk("vst_data", id_rs2_data, 32'h11223344);
        $display("txn VST r3,[r1]");

        // WAW: VLD r5 then VXORI r5 waits for wb r5
        drive(enc(4'hA, 3'd5, 3'd3, 3'd0), 1'b1);
        tick();
        chk("vld_memrd", id_mem_rd, 1);
        chk("vld_we", id_we, 1);
        drive(enc(4'h8, 3'd5, 3'd3, 3'd0), 1'b1);
        #1 chk("waw_stall", id_stall, 1);
        tick();
        chk("waw_bubble", id_valid, 0);
        wb(1'b1, 3'd5, 32'h55);
        #1 chk("waw_release", id_stall, 0);
        tick();
        wb(1'b0, 3'd0, 32'h0);
        chk("vxori_opcode", id_opcode, 4'h8);
        chk("vxori_valid", id_valid, 1);
        // r5 set and cleared together: must still be busy
        drive(enc(4'h8, 3'd0, 3'd5, 3'd0), 1'b1);
        #1 chk("set_wins_stall", id_stall, 1);
        wb(1'b1, 3'd5, 32'h66);
        tick();
        wb(1'b0, 3'd0, 32'h0);
        chk("raw5_valid", id_valid, 1);
        chk("raw5_bypass", id_rs1_data, 32'h66);
        $display("txn WAW on r5");

        // HALT parks the stage; writebacks still land; reset recovers
        drive(14'h3C00, 1'b1);
        tick();
        chk("halt_flag", halted, 1);
        chk("halt_bubble", id_valid, 0);
        drive(enc(4'h1, 3'd7, 3'd3, 3'd3), 1'b1);
        wb(1'b1, 3'd7, 32'h77);
        #1 chk("halt_stall", id_stall, 1);
        tick(); tick();
        wb(1'b0, 3'd0, 32'h0);
        chk("halt_no_issue", id_valid, 0);
        chk("halt_persist", halted, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(14'h0, 1'b0);
        chk("rst2_halted", halted, 0);
        chk("rst2_illegal", id_illegal, 0);
        #1 chk("rst2_stall", id_stall, 0);
        drive(enc(4'h1, 3'd1, 3'd3, 3'd7), 1'b1);
        tick();
        chk("rst2_valid", id_valid, 1);
        chk("rst2_rf_r3", id_rs1_data, 32'h0);
        chk("rst2_rf_r7", id_rs2_data, 32'h0);
        $display("txn HALT then reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
